set_assoc_cache: RTL and testbench

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

---
 rtl/set_assoc_cache.sv | 147 ++++++++++++++
 tb/tb_set_assoc_cache.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: 2-way set-associative read cache with write-through, LRU replacement and hit/miss counters
module set_assoc_cache #(
  parameter int SETS_LOG2    = 6,
  parameter int TAG_W        = 10,
  parameter int WRITE_POLICY = 0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_en,
  input  logic             write_en,
  input  logic [31:0]      address,
  input  logic [31:0]      write_data,
  output logic [31:0]      output_data,
  output logic             ready,
  output logic             read_en2sram,
  output logic             write_en2sram,
  output logic [31:0]      sram_address,
  output logic [31:0]      sram_wdata,
  input  logic             sram_ready,
  input  logic [63:0]      sram_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int SETS = 1 << SETS_LOG2;
  typedef enum logic [1:0] {IDLE, FILL, WTHRU} state_t;
  state_t state_q, state_d;
  logic [SETS-1:0] valid0_q, valid0_d, valid1_q, valid1_d, lru_q, lru_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [TAG_W-1:0] tag0_q [SETS];
  logic [TAG_W-1:0] tag1_q [SETS];
  logic [63:0] data0_q [SETS];
  logic [63:0] data1_q [SETS];
  logic [SETS_LOG2-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic word, hit0, hit1, hit, fill0, fill1, upd0, upd1;
  logic [63:0] hit_line, upd_line;
  assign idx = address[SETS_LOG2+2:3];
  assign tag = address[SETS_LOG2+TAG_W+2:SETS_LOG2+3];
  assign word = address[2];
  assign hit0 = valid0_q[idx] && tag0_q[idx] == tag;
  assign hit1 = valid1_q[idx] && tag1_q[idx] == tag;
  assign hit = hit0 | hit1;
  assign hit_line = hit0 ? data0_q[idx] : data1_q[idx];
  assign upd_line = word ? {write_data, hit_line[31:0]} : {hit_line[63:32], write_data};
  assign read_en2sram = state_q == FILL;
  assign write_en2sram = state_q == WTHRU;
  assign sram_address = read_en2sram ? {address[31:3], 3'b000} : address;
  assign sram_wdata = write_data;
  assign hit_cnt = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  always_comb begin
    state_d = state_q;
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    lru_d = lru_q;
    hit_cnt_d = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    ready = 1'b0;
    output_data = '0;
    fill0 = 1'b0;
    fill1 = 1'b0;
    upd0 = 1'b0;
    upd1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (write_en) begin
          state_d = WTHRU;
        end else if (read_en && hit) begin
          ready = 1'b1;
          output_data = word ? hit_line[63:32] : hit_line[31:0];
          lru_d[idx] = hit1;
          hit_cnt_d = &hit_cnt_q ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
        end else if (read_en) begin
          state_d = FILL;
          miss_cnt_d = &miss_cnt_q ? miss_cnt_q : miss_cnt_q + CNT_W'(1);
        end
      end
      FILL: begin
        if (sram_ready) begin
          ready = 1'b1;
          output_data = word ? sram_rdata[63:32] : sram_rdata[31:0];
          state_d = IDLE;
          fill0 = lru_q[idx];
          fill1 = !lru_q[idx];
          valid0_d[idx] = valid0_q[idx] | fill0;
          valid1_d[idx] = valid1_q[idx] | fill1;
          lru_d[idx] = fill1;
        end
      end
      WTHRU: begin
        if (sram_ready) begin
          ready = 1'b1;
          state_d = IDLE;
          if (hit && WRITE_POLICY == 0) begin
            valid0_d[idx] = valid0_q[idx] & !hit0;
            valid1_d[idx] = valid1_q[idx] & hit0;
            lru_d[idx] = hit0;
          end else if (hit) begin
            upd0 = hit0;
            upd1 = !hit0;
            lru_d[idx] = hit1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // nothing completes and no array is written while reset is asserted
    if (!rst) begin
      ready = 1'b0;
      output_data = '0;
      fill0 = 1'b0;
      fill1 = 1'b0;
      upd0 = 1'b0;
      upd1 = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q <= '0;
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      lru_q <= lru_d;
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (fill0) begin
      data0_q[idx] <= sram_rdata;
      tag0_q[idx] <= tag;
    end
    if (fill1) begin
      data1_q[idx] <= sram_rdata;
      tag1_q[idx] <= tag;
    end
    if (upd0) data0_q[idx] <= upd_line;
    if (upd1) data1_q[idx] <= upd_line;
  end
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: two caches (invalidate policy with 4-bit counters, update policy with 16-bit counters)
// driven by directed and random requests and scored against a recency-list cache model over a memory model.
module tb_set_assoc_cache;
  logic clk = 1'b0;
  logic [1:0] rstv = '0, re = '0, we = '0, srdy = '0;
  logic [1:0] rdy, r2s, w2s;
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic [31:0] od [2];
  logic [31:0] sa [2];
  logic [31:0] swd [2];
  logic [63:0] srd [2];
  logic [3:0] hc0, mc0;
  logic [15:0] hc1, mc1;
  int cyc = 0, checks = 0, fails = 0;
  bit hold [2];
  int cnt [2];
  typedef struct {logic [31:0] data; bit w; bit hit; int cyc;} exp_t;
  exp_t sb0 [$];
  exp_t sb1 [$];
  int rec [2][64][2];
  int mh [2];
  int mm [2];
  int lim [2] = '{15, 65535};
  logic [63:0] rmem [int];
  logic [63:0] smem [int];

  set_assoc_cache #(.WRITE_POLICY(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rstv[0]), .read_en(re[0]), .write_en(we[0]), .address(addr[0]), .write_data(wd[0]),
    .output_data(od[0]), .ready(rdy[0]), .read_en2sram(r2s[0]), .write_en2sram(w2s[0]),
    .sram_address(sa[0]), .sram_wdata(swd[0]), .sram_ready(srdy[0]), .sram_rdata(srd[0]),
    .hit_cnt(hc0), .miss_cnt(mc0));
  set_assoc_cache #(.WRITE_POLICY(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rstv[1]), .read_en(re[1]), .write_en(we[1]), .address(addr[1]), .write_data(wd[1]),
    .output_data(od[1]), .ready(rdy[1]), .read_en2sram(r2s[1]), .write_en2sram(w2s[1]),
    .sram_address(sa[1]), .sram_wdata(swd[1]), .sram_ready(srdy[1]), .sram_rdata(srd[1]),
    .hit_cnt(hc1), .miss_cnt(mc1));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] line_init(input int k);
    logic [31:0] x;
    x = 32'(k) * 32'h9E3779B1;
    return {x ^ 32'hDEADBEEF, x + 32'h13579BDF};
  endfunction

  function automatic logic [31:0] raddr();
    return {13'b0, 10'($urandom_range(3, 0)), 6'($urandom_range(3, 0)), 3'($urandom_range(7, 0))};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk_cnt(input int d);
    chk($sformatf("hit_cnt%0d", d), d == 0 ? 16'(hc0) : hc1, 64'(mh[d]));
    chk($sformatf("miss_cnt%0d", d), d == 0 ? 16'(mc0) : mc1, 64'(mm[d]));
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rdy[d]) begin
          if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            checks++;
            fails++;
            $display("FAIL unexpected_ready%0d: got ready=1 expected no pending request", d);
          end else begin
            if (d == 0) e = sb0.pop_front();
            else e = sb1.pop_front();
            chk($sformatf("output_data%0d", d), od[d], e.data);
            chk($sformatf("same_cycle_ready%0d", d), 64'(cyc == e.cyc), 64'(e.hit));
          end
        end
      end
    end
  endtask

  // SRAM: answers each request after 0-3 idle cycles, keeps its own memory image
  task automatic sram_model();
    int k;
    logic [63:0] l;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (srdy[d]) srdy[d] = 1'b0;
        else if (!hold[d] && (r2s[d] === 1'b1 || w2s[d] === 1'b1)) begin
          if (cnt[d] == 0) begin
            k = d * (1 << 20) + int'(sa[d][18:3]);
            l = smem.exists(k) ? smem[k] : line_init(k);
            if (w2s[d]) begin
              if (sa[d][2]) l[63:32] = swd[d];
              else l[31:0] = swd[d];
              smem[k] = l;
            end else srd[d] = l;
            srdy[d] = 1'b1;
            cnt[d] = $urandom_range(3, 0);
          end else cnt[d]--;
        end
      end
    end
  endtask

  task automatic clear_model(input int d);
    for (int s = 0; s < 64; s++) begin
      rec[d][s][0] = -1;
      rec[d][s][1] = -1;
    end
    mh[d] = 0;
    mm[d] = 0;
  endtask

  task automatic do_reset(input int d);
    rstv[d] = 1'b0;
    @(posedge clk);
    #1;
    rstv[d] = 1'b1;
    clear_model(d);
    chk_cnt(d);
    chk($sformatf("reset_idle%0d", d), {r2s[d], w2s[d], rdy[d]}, 3'b000);
  endtask

  // rec[d][s][0] is the most recently used resident tag, [1] the other one; -1 = empty slot
  task automatic op(input int d, input bit w, input bit ralso, input logic [31:0] a, input logic [31:0] wdat);
    exp_t e;
    int s, t, k;
    bit h, done;
    logic [63:0] l;
    s = int'(a[8:3]);
    t = int'(a[18:9]);
    k = d * (1 << 20) + int'(a[18:3]);
    l = rmem.exists(k) ? rmem[k] : line_init(k);
    h = rec[d][s][0] == t || rec[d][s][1] == t;
    e.w = w;
    e.hit = h && !w;
    e.data = w ? 32'h0 : (a[2] ? l[63:32] : l[31:0]);
    if (w) begin
      if (a[2]) l[63:32] = wdat;
      else l[31:0] = wdat;
      rmem[k] = l;
      if (h && d == 0) begin
        if (rec[d][s][0] == t) rec[d][s][0] = rec[d][s][1];
        rec[d][s][1] = -1;
      end else if (h && rec[d][s][1] == t) begin
        rec[d][s][1] = rec[d][s][0];
        rec[d][s][0] = t;
      end
    end else if (h) begin
      if (rec[d][s][1] == t) begin
        rec[d][s][1] = rec[d][s][0];
        rec[d][s][0] = t;
      end
      mh[d] = mh[d] < lim[d] ? mh[d] + 1 : mh[d];
    end else begin
      rec[d][s][1] = rec[d][s][0];
      rec[d][s][0] = t;
      mm[d] = mm[d] < lim[d] ? mm[d] + 1 : mm[d];
    end
    e.cyc = cyc;
    if (d == 0) sb0.push_back(e);
    else sb1.push_back(e);
    re[d] = ralso | !w;
    we[d] = w;
    addr[d] = a;
    wd[d] = wdat;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (i == 1 && !e.hit) begin
        chk($sformatf("sram_rd_req%0d", d), r2s[d], !w);
        chk($sformatf("sram_wr_req%0d", d), w2s[d], w);
        chk($sformatf("sram_addr%0d", d), sa[d], w ? a : {a[31:3], 3'b000});
      end
      done = rdy[d];
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL timeout%0d: got no ready within 40 cycles expected ready for address %h", d, a);
      if (d == 0) void'(sb0.pop_back());
      else void'(sb1.pop_back());
    end
    @(posedge clk);
    #1;
    re[d] = 1'b0;
    we[d] = 1'b0;
    chk_cnt(d);
  endtask

  task automatic reset_mid_fill(input int d, input logic [31:0] a);
    op(d, 0, 0, a, 0);
    op(d, 0, 0, a, 0);
    hold[d] = 1'b1;
    re[d] = 1'b1;
    addr[d] = 32'h0000_0E38;
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("fill_req_before_reset%0d", d), r2s[d], 1'b1);
    rstv[d] = 1'b0;
    @(posedge clk);
    #1;
    rstv[d] = 1'b1;
    re[d] = 1'b0;
    clear_model(d);
    @(negedge clk);
    chk($sformatf("fill_req_after_reset%0d", d), {r2s[d], rdy[d]}, 2'b00);
    hold[d] = 1'b0;
    @(posedge clk);
    #1;
    op(d, 0, 0, a, 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0;
      wd[d] = '0;
      hold[d] = 1'b0;
      cnt[d] = 0;
    end
    fork
      monitor();
      sram_model();
    join_none
    do_reset(0);
    do_reset(1);
    op(0, 0, 0, 32'h0000_0204, 0);
    op(0, 0, 0, 32'h0000_0200, 0);
    op(1, 0, 0, 32'h0000_0228, 0);
    op(1, 0, 0, 32'h0000_0428, 0);
    op(1, 0, 0, 32'h0000_022C, 0);
    op(1, 0, 0, 32'h0000_0628, 0);
    op(1, 0, 0, 32'h0000_0228, 0);
    op(1, 0, 0, 32'h0000_0428, 0);
    op(0, 0, 0, 32'h0000_0A10, 0);
    op(0, 1, 0, 32'h0000_0A10, 32'h1234_5678);
    op(0, 0, 0, 32'h0000_0A10, 0);
    op(1, 0, 0, 32'h0000_0A10, 0);
    op(1, 1, 0, 32'h0000_0A10, 32'h1234_5678);
    op(1, 0, 0, 32'h0000_0A10, 0);
    op(1, 0, 0, 32'h0000_0A14, 0);
    op(0, 1, 1, 32'h0000_0C08, 32'hCAFE_F00D);
    op(1, 1, 1, 32'h0000_0C08, 32'hCAFE_F00D);
    reset_mid_fill(0, 32'h0000_0E08);
    reset_mid_fill(1, 32'h0000_0E08);
    do_reset(0);
    for (int n = 0; n < 18; n++) op(0, 0, 0, 32'h0000_0318, 0);
    chk("hit_cnt_saturated", hc0, 64'hF);
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 250; n++) begin
        if ($urandom_range(99, 0) == 0) do_reset(d);
        else op(d, $urandom_range(2, 0) == 0, $urandom_range(1, 0) == 1, raddr(), $urandom);
      end
    end
    repeat (3) @(posedge clk);
    chk("scoreboard0_drained", 64'(sb0.size()), 64'd0);
    chk("scoreboard1_drained", 64'(sb1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
